writeback_regfile: RTL
======================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, on ports clk and rst_n.
REQ-002 Parameter RSP_IDX, default 4, SHALL set the stack-pointer register index.
REQ-003 Parameter RNONE, default 4'hF, SHALL encode "no register".
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port wb_en  input  1  a retiring instruction is valid this cycle.
REQ-007 Port icode  input  4  Y86 instruction code.
REQ-008 Port rA, rB  input  4 each  register specifiers.
REQ-009 Port cnd  input  1  condition outcome, used by cmovXX.
REQ-010 Port mem_err  input  1  data-memory address error for this instruction.
REQ-011 Port valE, valM  input  64 each  ALU result and memory result.
REQ-012 Port value0..value14  output  64 each  current register contents, feeding the decode stage combinationally.
REQ-013 Port stat  output  3  status code: 1 AOK, 2 HLT, 3 ADR, 4 INS.
REQ-014 Port halted  output  1  high in any non-AOK state.

Function
REQ-015 dstE SHALL be selected as follows: icode 2 gives rB if cnd=1, else RNONE; icode 3 and 6 give rB; icode 8, 9, A and B give RSP_IDX; every other icode gives RNONE.
REQ-016 dstM SHALL be rA for icode 5 and B, and RNONE for every other icode.
REQ-017 The valE write to dstE and the valM write to dstM SHALL both occur on the same rising clk edge in which wb_en=1 and the state is RUN, so the write latency is 1 cycle.
REQ-018 When dstE equals dstM and neither is RNONE (e.g. popq %rsp), valM SHALL win.
REQ-019 A destination equal to RNONE SHALL produce no write.
REQ-020 value0..value14 SHALL reflect the register array only, with no bypass of same-cycle write data; a write becomes visible in the cycle after the edge.
REQ-021 The state machine SHALL have the states RUN, HALT, ADR and INS, with RUN as the reset state.
REQ-022 In RUN with wb_en=1, icode 0 SHALL cause no writes and move the state to HALT.
REQ-023 In RUN with wb_en=1, icode > B SHALL cause no writes and move the state to INS.
REQ-024 In RUN with wb_en=1, mem_err=1 SHALL suppress the valM write, still perform the valE write, and move the state to ADR.
REQ-025 If icode 0 or icode > B occurs together with mem_err, INS SHALL take priority over ADR, and ADR over HLT.
REQ-026 HALT, ADR and INS SHALL be absorbing: all writes are ignored and the state is left only by reset.
REQ-027 With wb_en=0, the block SHALL make no writes and no state change.
REQ-028 stat SHALL be driven combinationally from the state.

Reset
REQ-029 Assertion of rst_n=0 SHALL asynchronously clear all 15 registers to 0, set the state to RUN, stat to 1 and halted to 0.
REQ-030 Reset asserted in the same cycle as a write SHALL discard that write.
REQ-031 Reset SHALL take effect mid-operation from any state.
REQ-032 The first write after reset SHALL occur on the first rising edge at which rst_n=1 and wb_en=1.

Structure
REQ-033 The icode constants (HALT..POPQ), the stat codes, RSP_IDX/RNONE defaults and the state enumeration SHALL live in a shared y86 constants package.
REQ-034 The destination-select logic SHALL be one sub-module, wb_dst_sel (inputs icode, rA, rB, cnd; outputs dstE, dstM), reusable by the later pipelined hazard logic.

Verification
REQ-035 Reset, then icode 3, rB=2, valE=0x1234 with wb_en pulse -> value2=0x1234 the next cycle, all other registers 0, stat=1.
REQ-036 icode 2, rB=5, valE=7, cnd=0 -> value5 unchanged; repeat with cnd=1 -> value5=7.
REQ-037 icode B, rA=4, valE=0x108, valM=0xAA -> value4=0xAA (dstM wins).
REQ-038 icode 5, rA=1, valE=9, valM=0x55, mem_err=1 -> value1 unchanged, stat=3, halted=1; a subsequent icode 3 write -> ignored.
REQ-039 icode 0 -> stat=2; then icode C alone -> stat stays 2 (absorbing); fresh reset -> icode C -> stat=4; icode C with mem_err=1 -> stat=4 (INS priority).
REQ-040 Assert rst_n=0 asynchronously between edges after writes to value0, value7 and value14 -> all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/writeback_regfile_pkg.sv
// Y86 constants shared by the writeback stage and, later, the pipeline hazard logic.
// Contains the icodes, stat codes, register-specifier defaults and the status state type.
package writeback_regfile_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_CMOVXX = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] RSP_IDX_DEF = 4'd4;
    localparam logic [3:0] RNONE_DEF   = 4'hF;
    localparam int         NUM_REGS    = 15;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_ADR,
        ST_INS
    } wb_state_e;

    function automatic logic [2:0] state_to_stat(input wb_state_e s);
        case (s)
            ST_HALT: return STAT_HLT;
            ST_ADR:  return STAT_ADR;
            ST_INS:  return STAT_INS;
            default: return STAT_AOK;
        endcase
    endfunction

endpackage

// File: rtl/writeback_regfile_dst_sel.sv
// Destination-register selection for the E and M write ports of a Y86 instruction.
// Purely combinational so the pipelined hazard logic can instantiate it unchanged.
module wb_dst_sel
    import writeback_regfile_pkg::*;
#(
    parameter logic [3:0] RSP_IDX = RSP_IDX_DEF,
    parameter logic [3:0] RNONE   = RNONE_DEF
) (
    input  logic [3:0] icode,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    input  logic       cnd,
    output logic [3:0] dstE,
    output logic [3:0] dstM
);

    // NOTE: outputs get a default before the case so no path through the block infers a latch.
    always_comb begin
        dstE = RNONE;
        case (icode)
            ICODE_CMOVXX:                                     dstE = cnd ? rB : RNONE;
            ICODE_IRMOVQ, ICODE_OPQ:                          dstE = rB;
            ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ:   dstE = RSP_IDX;
            ICODE_HALT, ICODE_NOP, ICODE_RMMOVQ, ICODE_MRMOVQ,
            ICODE_JXX:                                        dstE = RNONE;
            default:                                          dstE = RNONE;
        endcase
    end

    always_comb begin
        dstM = RNONE;
        case (icode)
            ICODE_MRMOVQ, ICODE_POPQ: dstM = rA;
            default:                  dstM = RNONE;
        endcase
    end

endmodule

// File: rtl/writeback_regfile.sv
// Y86 writeback stage: 15-entry register file with E/M write ports and the
// processor status machine (RUN until a halt, address error or bad instruction).
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter logic [3:0] RSP_IDX = RSP_IDX_DEF,
    parameter logic [3:0] RNONE   = RNONE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_en,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic        mem_err,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    output logic [63:0] value0,
    output logic [63:0] value1,
    output logic [63:0] value2,
    output logic [63:0] value3,
    output logic [63:0] value4,
    output logic [63:0] value5,
    output logic [63:0] value6,
    output logic [63:0] value7,
    output logic [63:0] value8,
    output logic [63:0] value9,
    output logic [63:0] value10,
    output logic [63:0] value11,
    output logic [63:0] value12,
    output logic [63:0] value13,
    output logic [63:0] value14,
    output logic [2:0]  stat,
    output logic        halted
);

    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] regs [NUM_REGS];
    wb_state_e   state;
    wb_state_e   state_next;
    logic        can_write;
    logic        we_e;
    logic        we_m;

    wb_dst_sel #(
        .RSP_IDX (RSP_IDX),
        .RNONE   (RNONE)
    ) u_dst_sel (
        .icode (icode),
        .rA    (rA),
        .rB    (rB),
        .cnd   (cnd),
        .dstE  (dstE),
        .dstM  (dstM)
    );

    // halt and illegal icodes never write, whatever the selector returns
    assign can_write = wb_en && (state == ST_RUN)
                       && (icode != ICODE_HALT) && (icode <= ICODE_POPQ);
    assign we_e = can_write && (dstE != RNONE) && (dstE < 4'(NUM_REGS));
    assign we_m = can_write && !mem_err && (dstM != RNONE) && (dstM < 4'(NUM_REGS));

    // NOTE: the register array is reset because software expects all registers to start at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // M port checked first so popq %rsp keeps the loaded value
                if (we_m && (dstM == 4'(i)))      regs[i] <= valM;
                else if (we_e && (dstE == 4'(i))) regs[i] <= valE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == ST_RUN && wb_en) begin
            if (icode > ICODE_POPQ)       state_next = ST_INS;
            else if (mem_err)             state_next = ST_ADR;
            else if (icode == ICODE_HALT) state_next = ST_HALT;
        end
    end

    always_comb begin
        stat   = state_to_stat(state);
        halted = (state != ST_RUN);
    end

    assign value0  = regs[0];
    assign value1  = regs[1];
    assign value2  = regs[2];
    assign value3  = regs[3];
    assign value4  = regs[4];
    assign value5  = regs[5];
    assign value6  = regs[6];
    assign value7  = regs[7];
    assign value8  = regs[8];
    assign value9  = regs[9];
    assign value10 = regs[10];
    assign value11 = regs[11];
    assign value12 = regs[12];
    assign value13 = regs[13];
    assign value14 = regs[14];

endmodule
